// File: rtl/pts_num_reader_pkg.sv
// Shared definitions for the point-count reader.
//   N_DEF   default width of the point count
//   AW_DEF  default width of the point-buffer address
//   state_t controller state encoding (IDLE=0, RUN=1, DONE=2)
package pts_num_reader_pkg;

  localparam int N_DEF  = 11;
  localparam int AW_DEF = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pts_num_reader_if.sv
// Request/response bundle of the point-count reader.
//   start/num/base : batch request (requester -> reader)
//   addr/valid/last: read-address stream (reader -> buffer side)
//   ready          : buffer side accepts addr this cycle
//   busy/done      : reader status
// slave modport is the reader's view, master is the requester/consumer view.
interface pts_num_reader_if
  import pts_num_reader_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int AW = AW_DEF
) ();

  logic          start;
  logic [N-1:0]  num;
  logic [AW-1:0] base;
  logic [AW-1:0] addr;
  logic          valid;
  logic          ready;
  logic          last;
  logic          busy;
  logic          done;

  modport slave (
    input  start, num, base, ready,
    output addr, valid, last, busy, done
  );

  modport master (
    output start, num, base, ready,
    input  addr, valid, last, busy, done
  );

endinterface

// File: rtl/pts_num_reader_cnt_pts_down.sv
// Remaining-point down-counter.
//   clk, rst : clock and synchronous active-high reset
//   ce       : clock enable, counter frozen when low
//   load     : load load_val (takes priority over dec)
//   dec      : decrement by one; saturates at zero so it never underflows
//   is_one   : count equals one (final request of the batch)
module cnt_pts_down
  import pts_num_reader_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         dec,
  output logic         is_one
);

  logic [N-1:0] count_q;
  logic [N-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - N'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (ce) begin
      count_q <= count_d;
    end
  end

  assign is_one = (count_q == N'(1));

endmodule

// File: rtl/pts_num_reader.sv
// Point-count reader: on start, streams num consecutive buffer addresses
// beginning at base (wrapping modulo 2^AW) under a valid/ready handshake,
// then pulses done for one cycle.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset, overrides everything
//   ce   : clock enable, all state frozen when low
//   bus  : pts_num_reader_if slave (start/num/base in, addr/valid/last/
//          busy/done out, ready in)
module pts_num_reader
  import pts_num_reader_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int AW = AW_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  pts_num_reader_if.slave bus
);

  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;
  logic          cnt_load;
  logic          cnt_dec;
  logic          cnt_is_one;

  cnt_pts_down #(.N(N)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .load     (cnt_load),
    .load_val (bus.num),
    .dec      (cnt_dec),
    .is_one   (cnt_is_one)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        if (bus.start) begin
          if (bus.num != '0) begin
            addr_d   = bus.base;
            cnt_load = 1'b1;
            state_d  = ST_RUN;
          end else begin
            // Empty batch: report completion without issuing any request.
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        // valid is implied by ST_RUN, so ready alone qualifies the handshake
        // here; ce gates the actual register update.
        if (bus.ready) begin
          cnt_dec = 1'b1;
          if (cnt_is_one) begin
            state_d = ST_DONE;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
      end
      ST_DONE: begin
        // addr keeps the final address during DONE and returns to its idle
        // value of zero together with the state.
        addr_d  = '0;
        state_d = ST_IDLE;
      end
      default: begin
        addr_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else if (ce) begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.addr  = addr_q;
  assign bus.valid = (state_q == ST_RUN);
  assign bus.last  = (state_q == ST_RUN) && cnt_is_one;
  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_pts_num_reader.sv
// Self-checking bench for pts_num_reader. Expected addresses are pushed to a
// scoreboard queue when a batch is started and compared as the reader
// presents them; each accepted address pops one entry.
module tb_pts_num_reader;
  import pts_num_reader_pkg::*;

  localparam int N  = N_DEF;
  localparam int AW = AW_DEF;

  typedef struct {
    logic [AW-1:0] addr;
    logic          last;
  } exp_t;

  logic clk;
  logic rst;
  logic ce;

  int tests_run    = 0;
  int tests_failed = 0;

  exp_t exp_q[$];

  pts_num_reader_if #(.N(N), .AW(AW)) bus ();

  pts_num_reader #(.N(N), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_expected(input int n, input logic [AW-1:0] b);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = b + AW'(i);
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  // Leaves the bench one edge after the start edge (+1 time unit).
  task automatic start_batch(input int n, input logic [AW-1:0] b, input bit hold);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.num   = N'(n);
    bus.base  = b;
    push_expected(n, b);
    $display("[TB] start num=%0d base=0x%0h hold=%0d", n, b, hold);
    @(posedge clk); #1;
    bus.start = hold;
  endtask

  // Consumes the queued batch with the given per-cycle ready/ce patterns
  // (bit i used on RUN cycle i, 1 beyond bit 31), then checks the done
  // pulse and the return to idle. exp_cycles < 0 skips the cycle count.
  task automatic drain(input logic [31:0] rdy_pat, input logic [31:0] ce_pat, input int exp_cycles);
    int cyc = 0;
    while (exp_q.size() > 0 && cyc < 5000) begin
      bus.ready = (cyc < 32) ? rdy_pat[cyc] : 1'b1;
      ce        = (cyc < 32) ? ce_pat[cyc]  : 1'b1;
      @(negedge clk);
      check_val("valid", 32'(bus.valid), 32'd1);
      check_val("addr",  32'(bus.addr),  32'(exp_q[0].addr));
      check_val("last",  32'(bus.last),  32'(exp_q[0].last));
      if (ce && bus.ready && bus.valid) begin
        $display("[TB] handshake addr=0x%0h last=%0d", bus.addr, bus.last);
        void'(exp_q.pop_front());
      end
      @(posedge clk); #1;
      cyc++;
    end
    check_val("drain_left", 32'(exp_q.size()), 32'd0);
    if (exp_cycles >= 0) check_val("run_cycles", 32'(cyc), 32'(exp_cycles));
    ce        = 1'b1;
    bus.ready = 1'b0;
    @(negedge clk);
    check_val("done_pulse", 32'(bus.done),  32'd1);
    check_val("done_busy",  32'(bus.busy),  32'd1);
    check_val("done_valid", 32'(bus.valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("idle_done",  32'(bus.done),  32'd0);
    check_val("idle_busy",  32'(bus.busy),  32'd0);
    check_val("idle_valid", 32'(bus.valid), 32'd0);
    check_val("idle_addr",  32'(bus.addr),  32'd0);
    $display("[TB] batch complete");
  endtask

  initial begin
    rst       = 1'b1;
    ce        = 1'b1;
    bus.start = 1'b1;       // reset must win over a simultaneous start
    bus.num   = N'(3);
    bus.base  = AW'(55);
    bus.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_val("rst_busy",  32'(bus.busy),  32'd0);
    check_val("rst_valid", 32'(bus.valid), 32'd0);
    check_val("rst_addr",  32'(bus.addr),  32'd0);
    check_val("rst_done",  32'(bus.done),  32'd0);
    check_val("rst_last",  32'(bus.last),  32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    check_val("idle_hold_busy", 32'(bus.busy), 32'd0);

    // Basic batch: 100,101,102 back to back.
    start_batch(3, AW'(100), 1'b0);
    drain(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);

    // Empty batch: straight to DONE with no valid.
    start_batch(0, AW'(5), 1'b0);
    drain(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    // Address wrap with ready pattern 1,0,1,1,0,1.
    start_batch(4, AW'('h1FFFE), 1'b0);
    drain(32'hFFFF_FFED, 32'hFFFF_FFFF, 6);

    // ce low for three RUN cycles.
    start_batch(5, AW'(300), 1'b0);
    drain(32'hFFFF_FFFF, 32'hFFFF_FFE3, 8);

    // Start held high: exactly one batch, next only after returning to IDLE.
    start_batch(2, AW'(50), 1'b1);
    drain(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    push_expected(2, AW'(50));
    @(posedge clk); #1;
    bus.start = 1'b0;
    drain(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    @(negedge clk);
    check_val("no_third_batch", 32'(bus.busy), 32'd0);

    // Reset after 2 of 5 handshakes.
    start_batch(5, AW'(200), 1'b0);
    bus.ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_val("pre_rst_addr", 32'(bus.addr), 32'(exp_q[0].addr));
      void'(exp_q.pop_front());
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_val("abort_valid", 32'(bus.valid), 32'd0);
    check_val("abort_busy",  32'(bus.busy),  32'd0);
    check_val("abort_done",  32'(bus.done),  32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("abort_no_done", 32'(bus.done), 32'd0);
    $display("[TB] reset abort checked");
    start_batch(2, AW'(7), 1'b0);
    drain(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);

    // Wrap from the top address with a single step.
    start_batch(2, AW'('h1FFFF), 1'b0);
    drain(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);

    // Random ready.
    start_batch(20, AW'($urandom_range(0, 'h1FFFF)), 1'b0);
    drain($urandom(), 32'hFFFF_FFFF, -1);

    // Maximum count.
    start_batch((1 << N) - 1, AW'(1000), 1'b0);
    drain(32'hFFFF_FFFF, 32'hFFFF_FFFF, (1 << N) - 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
